// File: rtl/phase_seq_timer.sv
// Wash-cycle phase sequencer: IDLE->DOOR->FILL->WASH->RINSE->SPIN->IDLE with prescaled tick timing.
// Optional pause support is compiled in with `define TIMER_PAUSE_EN.
module phase_seq_timer #(
    parameter int WIDTH       = 8,
    parameter int PRESCALE    = 1,
    parameter int T_DOOR      = 1,
    parameter int T_FILL      = 2,
    parameter int T_WASH_BASE = 4,
    parameter int T_WASH_STEP = 2,
    parameter int T_RINSE     = 4,
    parameter int T_SPIN      = 8,
    parameter int MAX_LOAD    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       pause,
    input  logic [1:0] load,
    output logic [2:0] phase,
    output logic       busy,
    output logic       td,
    output logic       tf,
    output logic       tw,
    output logic       tr,
    output logic       ts,
    output logic       done
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH+1:0] DMAX = {2'b00, {WIDTH{1'b1}}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DOOR  = 3'd1,
        FILL  = 3'd2,
        WASH  = 3'd3,
        RINSE = 3'd4,
        SPIN  = 3'd5
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] cnt;
    logic [PW-1:0]    pre;
    logic [1:0]       load_q;
    logic [WIDTH-1:0] dur;
    logic [WIDTH+1:0] wash_raw;
    logic             hold, tick_end, expire, accept;

    // Durations are saturated to the counter range and a zero count behaves as one tick.
    function automatic logic [WIDTH-1:0] sat_dur(input logic [WIDTH+1:0] v);
        if (v > DMAX)
            return DMAX[WIDTH-1:0];
        else if (v == '0)
            return WIDTH'(1);
        else
            return v[WIDTH-1:0];
    endfunction

`ifdef TIMER_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
    logic unused_pause;
    assign unused_pause = pause;
`endif

    assign wash_raw = (WIDTH+2)'(T_WASH_BASE) + (WIDTH+2)'(load_q) * (WIDTH+2)'(T_WASH_STEP);

    always_comb begin
        dur = WIDTH'(1);
        case (state)
            DOOR:    dur = sat_dur((WIDTH+2)'(T_DOOR));
            FILL:    dur = sat_dur((WIDTH+2)'(T_FILL));
            WASH:    dur = sat_dur(wash_raw);
            RINSE:   dur = sat_dur((WIDTH+2)'(T_RINSE));
            SPIN:    dur = sat_dur((WIDTH+2)'(T_SPIN));
            default: dur = WIDTH'(1);
        endcase
    end

    assign tick_end = (pre == PW'(PRESCALE - 1));
    assign expire   = (state != IDLE) && !hold && tick_end && (cnt == dur - WIDTH'(1));
    assign accept   = (state == IDLE) && start && !abort;

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic; abort wins over start and over expiry
    always_comb begin
        state_nx = state;
        if (abort)
            state_nx = IDLE;
        else if (accept)
            state_nx = DOOR;
        else if (expire) begin
            case (state)
                DOOR:    state_nx = FILL;
                FILL:    state_nx = WASH;
                WASH:    state_nx = RINSE;
                RINSE:   state_nx = SPIN;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Output decode
    always_comb begin
        phase = state;
        busy  = (state != IDLE);
    end

    // Tick counter and prescaler restart on every phase entry and freeze while held
    always_ff @(posedge clk) begin
        if (reset || abort || state == IDLE || expire) begin
            cnt <= '0;
            pre <= '0;
        end else if (!hold) begin
            if (tick_end) begin
                pre <= '0;
                cnt <= cnt + WIDTH'(1);
            end else begin
                pre <= pre + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            load_q <= '0;
        else if (accept)
            load_q <= (int'(load) > MAX_LOAD) ? 2'(MAX_LOAD) : load;
    end

    // Expiry pulses land in the first cycle of the following phase
    always_ff @(posedge clk) begin
        if (reset || abort) begin
            td   <= 1'b0;
            tf   <= 1'b0;
            tw   <= 1'b0;
            tr   <= 1'b0;
            ts   <= 1'b0;
            done <= 1'b0;
        end else begin
            td   <= expire && (state == DOOR);
            tf   <= expire && (state == FILL);
            tw   <= expire && (state == WASH);
            tr   <= expire && (state == RINSE);
            ts   <= expire && (state == SPIN);
            done <= expire && (state == SPIN);
        end
    end

endmodule
